run_mode_encoder: RTL

- Stage-4 consumer of the stage-3 pipeline registers.
- When do_run_encoding_4 is asserted, encodes the accumulated run count as JPEG-LS run-mode bits (ITU T.87 A.7.1): one '1' per full run segment, then either the run-interruption tail ('0' plus J low bits of the residual count) or the end-of-line flush bit.
- Owns the RUNindex update and hands variable-length codewords to the bit packer over a valid/ready handshake.

---
 rtl/run_mode_encoder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/run_mode_encoder.sv
// JPEG-LS run-mode encoder: turns an accumulated run count into run segment
// '1' bits plus an interruption tail or end-of-line flush, and updates RUNindex.
module run_mode_encoder #(
    parameter int runcount_length = 16,
    parameter int runindex_length = 5,
    parameter int code_length     = 16,
    parameter int len_length      = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start_enc_4,
    input  logic                       do_run_encoding_4,
    input  logic [runcount_length-1:0] run_length_4,
    input  logic [runindex_length-1:0] run_index_4,
    input  logic                       eol_4,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [code_length-1:0]     out_bits,
    output logic [len_length-1:0]      out_len,
    output logic [runindex_length-1:0] run_index_out,
    output logic                       run_index_valid,
    output logic                       done,
    output logic [2:0]                 fsm_state
);

    // Handshake: a codeword transfers on a rising edge where out_valid and
    // out_ready are both high; out_valid and its payload hold until then.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SCAN  = 3'd1,
        S_ONES  = 3'd2,
        S_TAIL  = 3'd3,
        S_FLUSH = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    localparam logic [runindex_length-1:0] IDX_MAX = '1;

    state_t                       state_q, state_d;
    logic [runcount_length-1:0]   cnt_q, cnt_d;
    logic [runindex_length-1:0]   idx_q, idx_d;
    logic                         eol_q, eol_d;
    logic [runindex_length-1:0]   run_index_q, run_index_d;

    logic [3:0]                   j_val;
    logic [runcount_length-1:0]   seg;
    logic [runcount_length-1:0]   tail_val;

    // J ROM from the RUNindex table.
    always_comb begin
        j_val = 4'd0;
        case (idx_q)
            5'd0, 5'd1, 5'd2, 5'd3:     j_val = 4'd0;
            5'd4, 5'd5, 5'd6, 5'd7:     j_val = 4'd1;
            5'd8, 5'd9, 5'd10, 5'd11:   j_val = 4'd2;
            5'd12, 5'd13, 5'd14, 5'd15: j_val = 4'd3;
            5'd16, 5'd17:               j_val = 4'd4;
            5'd18, 5'd19:               j_val = 4'd5;
            5'd20, 5'd21:               j_val = 4'd6;
            5'd22, 5'd23:               j_val = 4'd7;
            5'd24:                      j_val = 4'd8;
            5'd25:                      j_val = 4'd9;
            5'd26:                      j_val = 4'd10;
            5'd27:                      j_val = 4'd11;
            5'd28:                      j_val = 4'd12;
            5'd29:                      j_val = 4'd13;
            5'd30:                      j_val = 4'd14;
            default:                    j_val = 4'd15;
        endcase
    end

    assign seg      = runcount_length'(1) << j_val;
    // Bit J of the masked residual is always zero, which supplies the leading '0'.
    assign tail_val = cnt_q & (seg - runcount_length'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            eol_q       <= 1'b0;
            run_index_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            eol_q       <= eol_d;
            run_index_q <= run_index_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        eol_d       = eol_q;
        run_index_d = run_index_q;
        case (state_q)
            S_IDLE: begin
                if (do_run_encoding_4 && start_enc_4) begin
                    cnt_d   = run_length_4;
                    idx_d   = run_index_4;
                    eol_d   = eol_4;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (cnt_q >= seg)
                    state_d = S_ONES;
                else if (eol_q)
                    state_d = (cnt_q != '0) ? S_FLUSH : S_FIN;
                else
                    state_d = S_TAIL;
            end
            S_ONES: begin
                if (out_ready) begin
                    cnt_d   = cnt_q - seg;
                    if (idx_q != IDX_MAX)
                        idx_d = idx_q + runindex_length'(1);
                    state_d = S_SCAN;
                end
            end
            S_TAIL: begin
                if (out_ready) begin
                    if (idx_q != '0)
                        idx_d = idx_q - runindex_length'(1);
                    state_d = S_FIN;
                end
            end
            S_FLUSH: begin
                if (out_ready)
                    state_d = S_FIN;
            end
            S_FIN: begin
                run_index_d = idx_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_bits  = '0;
        out_len   = '0;
        case (state_q)
            S_ONES, S_FLUSH: begin
                out_valid = 1'b1;
                out_bits  = code_length'(1);
                out_len   = len_length'(1);
            end
            S_TAIL: begin
                out_valid = 1'b1;
                out_bits  = code_length'(tail_val);
                out_len   = len_length'(j_val) + len_length'(1);
            end
            default: ;
        endcase
    end

    assign in_ready        = (state_q == S_IDLE);
    assign done            = (state_q == S_FIN);
    assign run_index_valid = (state_q == S_FIN);
    assign run_index_out   = (state_q == S_FIN) ? idx_q : run_index_q;
    assign fsm_state       = state_q;

endmodule
